hazard_ctrl: RTL and testbench

- Hazard/forwarding controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Sits beside the decode stage and watches the decoded instruction each cycle: source registers, destination register, RegWrite, ResultSrc.
- Keeps its own shadow copy of EX/MEM/WB destination info and produces stall, flush and forwarding-select signals for the pipeline registers and EX operand muxes.
- Register file is write-first (WB write visible to same-cycle ID read); this block does not bypass into ID.

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_ctrl_shadow_stage.sv | 22 ++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forwarding-select and ResultSrc encodings (also used by the control
// unit) plus the forwarding priority helper.
package hazard_ctrl_pkg;

  // EX operand mux select: register file, WB result or MEM result.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // ResultSrc encodings shared with the control unit.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Picks the operand source; the younger MEM result beats WB on a double hit.
  function automatic fwd_sel_e fwd_pick(input logic src_ok,
                                        input logic hit_m,
                                        input logic hit_w);
    if (!src_ok) return FWD_RF;
    if (hit_m)   return FWD_MEM;
    if (hit_w)   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_shadow_stage.sv
// hazard_shadow_stage: one shadow pipeline register used by the hazard
// controller. Clears to all-zero (an invalid, non-writing bubble) on
// synchronous reset or when a bubble is requested.
module hazard_shadow_stage
  import hazard_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the incoming stage fields, or insert a bubble.
  always_ff @(posedge clk) begin
    if (reset || bubble) q <= '0;
    else                 q <= d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller for the 5-stage RISC-V
// pipeline. Tracks a shadow copy of the EX/MEM/WB destination info and
// derives all control outputs combinationally from it and the ID inputs.
// Optional build macro: HAZARD_PERF_EN adds stall_cnt/flush_cnt counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_d,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rd_d,
  input  logic            use_rs1_d,
  input  logic            use_rs2_d,
  input  logic            regwrite_d,
  input  logic [1:0]      resultsrc_d,
  input  logic            branch_taken_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int EW = 3 * RA_W + 3;
  localparam int MW = RA_W + 2;

  logic [EW-1:0]   e_d, e_q;
  logic [MW-1:0]   m_d, m_q, w_q;
  logic            e_bubble;

  logic            e_valid, e_regwrite, e_is_load;
  logic [RA_W-1:0] e_rs1, e_rs2, e_rd;
  logic            m_valid, m_regwrite, w_valid, w_regwrite;
  logic [RA_W-1:0] m_rd, w_rd;
  logic            m_src, w_src, lu;
  fwd_sel_e        fwd_a, fwd_b;

  assign e_d      = {valid_d, rs1_d, rs2_d, rd_d, regwrite_d, (resultsrc_d == RES_MEM)};
  assign e_bubble = !valid_d || flush_e;
  assign m_d      = {e_valid, e_rd, e_regwrite};

  hazard_shadow_stage #(.W(EW)) u_stage_e (
    .clk(clk), .reset(reset), .bubble(e_bubble), .d(e_d), .q(e_q)
  );
  hazard_shadow_stage #(.W(MW)) u_stage_m (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(m_d), .q(m_q)
  );
  hazard_shadow_stage #(.W(MW)) u_stage_w (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(m_q), .q(w_q)
  );

  assign {e_valid, e_rs1, e_rs2, e_rd, e_regwrite, e_is_load} = e_q;
  assign {m_valid, m_rd, m_regwrite} = m_q;
  assign {w_valid, w_rd, w_regwrite} = w_q;

  // A stage can supply a result only if it really writes a non-x0 register.
  assign m_src = m_valid && m_regwrite && (m_rd != '0);
  assign w_src = w_valid && w_regwrite && (w_rd != '0);

  // Load in EX whose result the ID instruction needs next cycle.
  assign lu = e_valid && e_is_load && (e_rd != '0) && valid_d &&
              ((use_rs1_d && (rs1_d == e_rd)) || (use_rs2_d && (rs2_d == e_rd)));

  // Stall/flush/forward decode; everything held at 0 while reset is asserted.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a   = FWD_RF;
    fwd_b   = FWD_RF;
    if (!reset) begin
      stall_f = lu && !branch_taken_e;
      stall_d = lu && !branch_taken_e;
      flush_d = branch_taken_e;
      flush_e = branch_taken_e || lu;
      fwd_a   = fwd_pick(e_valid && (e_rs1 != '0),
                         m_src && (m_rd == e_rs1), w_src && (w_rd == e_rs1));
      fwd_b   = fwd_pick(e_valid && (e_rs2 != '0),
                         m_src && (m_rd == e_rs2), w_src && (w_rd == e_rs2));
    end
  end

  assign fwd_a_e = fwd_a;
  assign fwd_b_e = fwd_b;

`ifdef HAZARD_PERF_EN
  // Free-running wrap-around event counters for stalls and taken branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d)        stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken_e) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Each cycle's ID inputs
// are driven together with hand-derived expected outputs; a negedge monitor
// pops and compares them. Builds with or without HAZARD_PERF_EN.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       vd;
    logic [4:0] r1, r2, rd;
    logic       u1, u2, rw;
    logic [1:0] rs;
    logic       br;
    logic       st, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_d = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       use_rs1_d = 1'b0, use_rs2_d = 1'b0, regwrite_d = 1'b0;
  logic [1:0] resultsrc_d = '0;
  logic       branch_taken_e = 1'b0;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  int          exp_stall_cnt = 0, exp_flush_cnt = 0;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  vec_t vecs[$];
  vec_t sb[$];

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of ID inputs just after the edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset          = v.rst;
    valid_d        = v.vd;
    rs1_d          = v.r1;
    rs2_d          = v.r2;
    rd_d           = v.rd;
    use_rs1_d      = v.u1;
    use_rs2_d      = v.u2;
    regwrite_d     = v.rw;
    resultsrc_d    = v.rs;
    branch_taken_e = v.br;
    sb.push_back(v);
  endtask

  function automatic vec_t mk(input logic rst, input logic vd,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic u1, input logic u2, input logic rw,
                              input logic [1:0] rs, input logic br,
                              input logic st, input logic fd, input logic fe,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v = '{rst, vd, r1, r2, rd, u1, u2, rw, rs, br, st, fd, fe, fa, fb};
    return v;
  endfunction

  // Negedge monitor: pop the oldest expectation and compare every output.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      checkOutput($sformatf("c%0d stall_f", cyc), {31'b0, stall_f}, {31'b0, e.st});
      checkOutput($sformatf("c%0d stall_d", cyc), {31'b0, stall_d}, {31'b0, e.st});
      checkOutput($sformatf("c%0d flush_d", cyc), {31'b0, flush_d}, {31'b0, e.fd});
      checkOutput($sformatf("c%0d flush_e", cyc), {31'b0, flush_e}, {31'b0, e.fe});
      checkOutput($sformatf("c%0d fwd_a_e", cyc), {30'b0, fwd_a_e}, {30'b0, e.fa});
      checkOutput($sformatf("c%0d fwd_b_e", cyc), {30'b0, fwd_b_e}, {30'b0, e.fb});
`ifdef HAZARD_PERF_EN
      checkOutput($sformatf("c%0d stall_cnt", cyc), stall_cnt, exp_stall_cnt);
      checkOutput($sformatf("c%0d flush_cnt", cyc), flush_cnt, exp_flush_cnt);
      if (e.rst) begin
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
      end else begin
        exp_stall_cnt += int'(e.st);
        exp_flush_cnt += int'(e.br);
      end
`endif
      cyc++;
    end
  end

  initial begin
    //              rst vd r1 r2 rd u1 u2 rw rs   br | st fd fe fa fb
    // reset: inputs ignored, outputs 0
    vecs.push_back(mk(1, 1, 5, 6, 5, 1, 1, 1, 2'b01, 1, 0, 0, 0, 0, 0)); // c0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c2
    // back-to-back ALU dependency -> MEM forward
    vecs.push_back(mk(0, 1, 1, 2, 5, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c3 add x5
    vecs.push_back(mk(0, 1, 5, 3, 8, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c4 sub rs1=5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 0)); // c5 sub in EX
    // one independent instruction between -> WB forward
    vecs.push_back(mk(0, 1, 1, 2, 9, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c6 add x9
    vecs.push_back(mk(0, 1, 10, 11, 12, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c7
    vecs.push_back(mk(0, 1, 9, 0, 13, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c8 or rs1=9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0)); // c9
    // load-use: one-cycle stall then WB forward on rs2
    vecs.push_back(mk(0, 1, 1, 0, 6, 1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0)); // c10 lw x6
    vecs.push_back(mk(0, 1, 3, 6, 14, 1, 1, 1, 2'b00, 0, 1, 0, 1, 0, 0)); // c11 stall
    vecs.push_back(mk(0, 1, 3, 6, 14, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c12 held add
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1)); // c13
    // load to x0: never a hazard
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0)); // c14 lw x0
    vecs.push_back(mk(0, 1, 0, 4, 15, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c15
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c16
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c17
    // branch collides with load-use: branch wins
    vecs.push_back(mk(0, 1, 1, 0, 6, 1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0)); // c18 lw x6
    vecs.push_back(mk(0, 1, 6, 0, 16, 1, 0, 1, 2'b00, 1, 0, 1, 1, 0, 0)); // c19
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c20
    // x7 in both M and W: MEM wins
    vecs.push_back(mk(0, 1, 1, 2, 7, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c21
    vecs.push_back(mk(0, 1, 1, 2, 7, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c22
    vecs.push_back(mk(0, 1, 7, 7, 17, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c23
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 2)); // c24
    // reset during a load-use stall discards the in-flight load
    vecs.push_back(mk(0, 1, 1, 0, 6, 1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0)); // c25 lw x6
    vecs.push_back(mk(1, 1, 3, 6, 14, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c26 reset
    vecs.push_back(mk(0, 1, 3, 6, 14, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // c27
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c28 no WB fwd
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // c29

    foreach (vecs[i]) applyStimulus(vecs[i]);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
